inv_sub_bytes_iter: RTL and testbench

INV_SUB_BYTES_ITER -- requirements
Module: inv_sub_bytes_iter

---
 rtl/aes_dec_pkg.sv | 28 ++
 rtl/inv_sbox_byte.sv | 30 +++
 rtl/inv_sub_bytes_iter.sv | 96 +++++++++
 tb/tb_inv_sub_bytes_iter.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/aes_dec_pkg.sv
// Shared types and helpers for the iterative AES inverse-substitution datapath.
// InvShiftRows helper is used by inv_sub_bytes_iter when INV_SUB_BYTES_SHIFT_ROWS_EN is defined.
package aes_dec_pkg;

  localparam int NUM_BYTES = 16;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsm_t;

  // Byte i lives at [127-8i -: 8]; byte index = 4*col + row.
  function automatic state_t inv_shift_rows(state_t s);
    state_t r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int rw = 0; rw < 4; rw++) begin
        r[8*(15-(4*c+rw)) +: 8] = s[8*(15-(4*((c-rw+4)%4)+rw)) +: 8];
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/inv_sbox_byte.sv
// Combinational AES inverse S-box lookup for a single byte.
module inv_sbox_byte
  import aes_dec_pkg::*;
(
  input  logic [7:0] b,
  output logic [7:0] y
);

  localparam logic [0:255][7:0] TBL = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  assign y = TBL[b];

endmodule

// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES InvSubBytes: LANES bytes per cycle, valid/ready on both sides.
// Define INV_SUB_BYTES_SHIFT_ROWS_EN to fold InvShiftRows into the capture path.
module inv_sub_bytes_iter
  import aes_dec_pkg::*;
#(
  parameter int LANES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [127:0] in_state,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [127:0] out_state,
  output logic         out_valid,
  input  logic         out_ready
);

  localparam int NG = NUM_BYTES / LANES;
  localparam int CW = (NG > 1) ? $clog2(NG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NG - 1);

  fsm_t        state;
  logic [CW-1:0] cnt;
  state_t      work;
  state_t      cap;
  byte_t       sel [LANES];
  byte_t       sub [LANES];

`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
  assign cap = inv_shift_rows(in_state);
`else
  assign cap = in_state;
`endif

  // Group mux: lane l looks at byte LANES*cnt + l of the working register.
  always_comb begin
    for (int l = 0; l < LANES; l++) begin
      sel[l] = work[8*(NUM_BYTES-1-(LANES*int'(cnt)+l)) +: 8];
    end
  end

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    inv_sbox_byte u_sbox (.b(sel[g]), .y(sub[g]));
  end

  assign in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
  assign out_state = out_valid ? work : '0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      work      <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work  <= cap;
            cnt   <= '0;
            state <= BUSY;
          end
        end
        BUSY: begin
          for (int l = 0; l < LANES; l++) begin
            work[8*(NUM_BYTES-1-(LANES*int'(cnt)+l)) +: 8] <= sub[l];
          end
          if (cnt == LAST) begin
            state     <= DONE;
            out_valid <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          // Output handoff and a new capture may share the same edge.
          if (out_ready) begin
            out_valid <= 1'b0;
            if (in_valid) begin
              work  <= cap;
              cnt   <= '0;
              state <= BUSY;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state     <= IDLE;
          out_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Directed bench for inv_sub_bytes_iter at LANES = 4, 1 and 16.
module tb_inv_sub_bytes_iter;

  logic         clk = 1'b0;
  logic         rst_n;
  logic [127:0] in_state;
  logic         iv4, iv1, iv16;
  logic         ir4, ir1, ir16;
  logic [127:0] os4, os1, os16;
  logic         ov4, ov1, ov16;
  logic         or4, or1, or16;

  always #5 clk = ~clk;

  inv_sub_bytes_iter #(.LANES(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(iv4), .in_ready(ir4),
    .out_state(os4), .out_valid(ov4), .out_ready(or4));
  inv_sub_bytes_iter #(.LANES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(iv1), .in_ready(ir1),
    .out_state(os1), .out_valid(ov1), .out_ready(or1));
  inv_sub_bytes_iter #(.LANES(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .in_state(in_state), .in_valid(iv16), .in_ready(ir16),
    .out_state(os16), .out_valid(ov16), .out_ready(or16));

  typedef struct {
    logic [127:0] din;
    logic [127:0] exp;
  } vec_t;

  vec_t vecs [5];
  int checks = 0;
  int passed = 0;

  localparam logic [127:0] SEQ00 = 128'h000102030405060708090a0b0c0d0e0f;
`ifdef INV_SUB_BYTES_SHIFT_ROWS_EN
  localparam logic [127:0] EXP00 = 128'h52f3a3383009d79ebf366afb8140a5d5;
  localparam logic [127:0] EXP10 = 128'h7cde43879be3e944342f39cbc48eff82;
`else
  localparam logic [127:0] EXP00 = 128'h52096ad53036a538bf40a39e81f3d7fb;
  localparam logic [127:0] EXP10 = 128'h7ce339829b2fff87348e4344c4dee9cb;
`endif

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  // Offer d to the LANES=4 instance; returns latency in cycles (-1 on timeout).
  task automatic run4(input logic [127:0] d, output int lat, output logic busy_ready);
    int w;
    w = 0;
    while (!ir4 && w < 40) begin step(); w++; end
    in_state = d;
    iv4 = 1'b1;
    step();
    busy_ready = ir4;
    in_state = ~d;     // garbage offered while busy must be ignored
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ov4) begin lat = i; break; end
    end
    iv4 = 1'b0;
  endtask

  initial begin
    int lat, l1, l16;
    logic br;
    logic [127:0] held;

    vecs[0] = '{din: {16{8'h63}}, exp: {16{8'h00}}};
    vecs[1] = '{din: SEQ00,        exp: EXP00};
    vecs[2] = '{din: {16{8'hff}}, exp: {16{8'h7d}}};
    vecs[3] = '{din: {16{8'h00}}, exp: {16{8'h52}}};
    vecs[4] = '{din: 128'h101112131415161718191a1b1c1d1e1f, exp: EXP10};

    rst_n = 1'b0; in_state = '0;
    iv4 = 0; iv1 = 0; iv16 = 0; or4 = 0; or1 = 0; or16 = 0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("reset_in_ready", 128'(ir4), 128'(1));
    chk("reset_out_valid", 128'(ov4), 128'(0));
    chk("reset_out_state", os4, '0);

    for (int v = 0; v < 5; v++) begin
      run4(vecs[v].din, lat, br);
      chk($sformatf("v%0d_latency", v), 128'(lat), 128'(4));
      chk($sformatf("v%0d_busy_in_ready", v), 128'(br), 128'(0));
      chk($sformatf("v%0d_out_state", v), os4, vecs[v].exp);
      or4 = 1'b1;
      step();
      or4 = 1'b0;
      chk($sformatf("v%0d_after_take_valid", v), 128'(ov4), 128'(0));
      chk($sformatf("v%0d_after_take_state", v), os4, '0);
    end

    // Backpressure in DONE, then take + accept on the same edge.
    run4({16{8'h63}}, lat, br);
    held = os4;
    chk("bp_first", held, {16{8'h00}});
    for (int i = 0; i < 10; i++) begin
      step();
      chk($sformatf("bp_hold_state_%0d", i), os4, held);
      chk($sformatf("bp_hold_ready_%0d", i), 128'({ov4, ir4}), 128'(2'b10));
    end
    or4 = 1'b1;
    iv4 = 1'b1;
    in_state = SEQ00;
    #1;
    chk("bp_ready_with_out_ready", 128'(ir4), 128'(1));
    step();
    or4 = 1'b0; iv4 = 1'b0; in_state = '0;
    lat = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ov4) begin lat = i; break; end
    end
    chk("bp_next_latency", 128'(lat), 128'(4));
    chk("bp_next_state", os4, EXP00);
    or4 = 1'b1; step(); or4 = 1'b0;

    // Reset two cycles into BUSY discards the input.
    in_state = {16{8'hff}};
    iv4 = 1'b1;
    step();
    iv4 = 1'b0;
    step(); step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    #1;
    chk("rst_busy_in_ready", 128'(ir4), 128'(1));
    lat = 0;
    for (int i = 0; i < 10; i++) begin
      if (ov4) lat++;
      step();
    end
    chk("rst_busy_no_valid", 128'(lat), 128'(0));

    // Reset while DONE drops out_valid.
    run4({16{8'h00}}, lat, br);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("rst_done_valid", 128'(ov4), 128'(0));
    chk("rst_done_state", os4, '0);

    // Same vector on the LANES=1 and LANES=16 instances.
    in_state = SEQ00;
    iv1 = 1'b1; iv16 = 1'b1;
    step();
    iv1 = 1'b0; iv16 = 1'b0;
    l1 = -1; l16 = -1;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (ov1 && l1 < 0) l1 = i;
      if (ov16 && l16 < 0) l16 = i;
      if (l1 >= 0 && l16 >= 0) break;
    end
    chk("lanes1_latency", 128'(l1), 128'(16));
    chk("lanes16_latency", 128'(l16), 128'(1));
    chk("lanes1_state", os1, EXP00);
    chk("lanes16_state", os16, EXP00);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
